// File: rtl/online_pkg.sv
// Shared definitions for online (MSD-first) radix-4 signed-digit arithmetic.
// Used by the on-the-fly converter and by future pipelined converters.
package online_pkg;
   typedef logic signed [2:0] digit_t;

   localparam int     RADIX         = 4;
   localparam int     DIGIT_MIN     = -3;
   localparam int     DIGIT_MAX     = 3;
   localparam digit_t DIGIT_ILLEGAL = 3'b100;

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } conv_state_e;
endpackage

// File: rtl/otf_converter_if.sv
// Digit-in / result-out handshake bundle for the on-the-fly converter.
interface otf_converter_if #(parameter int P = 32);
   import online_pkg::*;
   localparam int OW = 2*P+1;

   digit_t          d_i;
   logic            d_valid_i;
   logic            d_ready_o;
   logic            abort_i;
   logic [OW-1:0]   q_o;
   logic            q_valid_o;
   logic            q_ready_i;
   logic            err_o;

   modport master (output d_i, d_valid_i, abort_i, q_ready_i,
                   input  d_ready_o, q_o, q_valid_o, err_o);
   modport slave  (input  d_i, d_valid_i, abort_i, q_ready_i,
                   output d_ready_o, q_o, q_valid_o, err_o);
endinterface

// File: rtl/otf_step.sv
// One on-the-fly conversion step: next (Q, QM) from current (Q, QM) and a digit.
// Invariant kept by the recurrence: QM == Q - 1 (mod 2^OW).
module otf_step
   import online_pkg::*;
#(
   parameter int OW = 9
) (
   input  logic [OW-1:0] q,
   input  logic [OW-1:0] qm,
   input  digit_t        d,
   output logic [OW-1:0] q_nxt,
   output logic [OW-1:0] qm_nxt
);
   logic [OW-1:0] d_ext;
   logic [OW-1:0] q4;
   logic [OW-1:0] qm4;
   logic          d_neg;
   logic          d_pos;

   // Full adds rather than a pure 2-bit append so the illegal code -4 still
   // yields the arithmetically correct value (4*QM-1 needs a borrow).
   always_comb begin
      d_ext  = {{(OW-3){d[2]}}, d};
      q4     = {q[OW-3:0], 2'b00};
      qm4    = {qm[OW-3:0], 2'b00};
      d_neg  = d[2];
      d_pos  = !d[2] && (d[1:0] != 2'b00);
      q_nxt  = d_neg ? (qm4 + d_ext + OW'(4)) : (q4 + d_ext);
      qm_nxt = d_pos ? (q4 + d_ext - OW'(1))  : (qm4 + d_ext + OW'(3));
   end
endmodule

// File: rtl/otf_converter.sv
// Radix-4 signed-digit (MSD first) to two's-complement on-the-fly converter.
// Accepts P digits, then holds the result until the downstream consumes it.
module otf_converter
   import online_pkg::*;
#(
   parameter int P = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   otf_converter_if.slave  bus
);
   localparam int OW = 2*P+1;
   localparam int CW = (P > 1) ? $clog2(P) : 1;

   conv_state_e    state, state_nxt;
   logic           alive;
   logic [OW-1:0]  q_r, qm_r, q_nxt, qm_nxt;
   logic [CW-1:0]  cnt;
   logic           err;
   logic           ready;
   logic           accept;
   logic           last;
   logic           clear;

   otf_step #(.OW(OW)) u_step (
      .q      (q_r),
      .qm     (qm_r),
      .d      (bus.d_i),
      .q_nxt  (q_nxt),
      .qm_nxt (qm_nxt)
   );

   // alive holds d_ready low until the first clock edge after reset release
   assign ready  = (state == ACC) && alive;
   assign accept = bus.d_valid_i && ready;
   assign last   = (cnt == CW'(P-1));
   assign clear  = ((state == ACC) && bus.abort_i) ||
                   ((state == DONE) && bus.q_ready_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (!bus.abort_i && accept && last) state_nxt = DONE;
         DONE:    if (bus.q_ready_i) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive <= 1'b0;
         q_r   <= '0;
         qm_r  <= '1;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         alive <= 1'b1;
         if (clear) begin
            q_r  <= '0;
            qm_r <= '1;
            cnt  <= '0;
            err  <= 1'b0;
         end else if (accept) begin
            q_r  <= q_nxt;
            qm_r <= qm_nxt;
            cnt  <= last ? '0 : cnt + CW'(1);
            if (bus.d_i == DIGIT_ILLEGAL) err <= 1'b1;
         end
      end
   end

   assign bus.d_ready_o = ready;
   assign bus.q_valid_o = (state == DONE);
   assign bus.q_o       = (state == DONE) ? q_r : '0;
   assign bus.err_o     = err;
endmodule
